// File: rtl/spi_txn_ctrl_pkg.sv
// spi_pkg: definitions shared by the SPI transaction controller files.
//   SPI_DATA_W      - width of one SPI byte (host and SPI side)
//   ST_*_CODE       - fixed state encodings, kept stable so older tools and scripts
//                     that decode the raw state bits keep working
//   spi_txn_state_t - controller FSM state type built on those encodings
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    localparam logic [1:0] ST_IDLE_CODE  = 2'd0;
    localparam logic [1:0] ST_ISSUE_CODE = 2'd1;
    localparam logic [1:0] ST_WAIT_CODE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_CODE,
        ST_ISSUE = ST_ISSUE_CODE,
        ST_WAIT  = ST_WAIT_CODE
    } spi_txn_state_t;

endpackage

// File: rtl/spi_txn_ctrl_if.sv
// spi_txn_ctrl_if: bundles the host TX/RX handshakes and the SPI-master strobes.
//   in_valid/in_data/in_ready      - host TX byte handshake
//   out_valid/out_data/out_ready   - host RX byte handshake
//   spi_start/spi_tx_data          - start pulse and byte towards the SPI master
//   spi_rx_data/spi_done           - received byte and completion pulse from it
// Modports:
//   slave  - the controller itself
//   master - the environment around it (host plus SPI master)
interface spi_txn_ctrl_if;
    import spi_pkg::*;

    logic                  in_valid;
    logic [SPI_DATA_W-1:0] in_data;
    logic                  in_ready;

    logic                  out_valid;
    logic [SPI_DATA_W-1:0] out_data;
    logic                  out_ready;

    logic                  spi_start;
    logic [SPI_DATA_W-1:0] spi_tx_data;
    logic [SPI_DATA_W-1:0] spi_rx_data;
    logic                  spi_done;

    modport slave (
        input  in_valid, in_data, out_ready, spi_rx_data, spi_done,
        output in_ready, out_valid, out_data, spi_start, spi_tx_data
    );

    modport master (
        output in_valid, in_data, out_ready, spi_rx_data, spi_done,
        input  in_ready, out_valid, out_data, spi_start, spi_tx_data
    );

endinterface

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: single-clock FIFO used for both the TX and the RX byte queues.
// Parameters: WIDTH (entry width), DEPTH (entries, power of two, 2..16).
// Ports:
//   clk, rst - clock and asynchronous active-high reset (empties the FIFO)
//   push, wdata - write request; ignored while full
//   pop         - read request; ignored while empty
//   rdata       - head entry, valid combinationally whenever !empty
//   full, empty, level - occupancy status
module spi_sync_fifo
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_DATA_W,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Gating with full/empty here makes overflow and underflow impossible
    // no matter what the caller requests.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == FULL_LEVEL);
    assign empty = (count == '0);
    assign level = count;
    assign rdata = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing reads it until an entry is written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/spi_txn_ctrl.sv
// spi_txn_ctrl: queues host bytes, issues them one at a time to an SPI master
// and queues the bytes that come back for the host.
// Parameter: DEPTH - entries per FIFO (power of two, 2..16).
// Ports:
//   clk, rst          - clock and asynchronous active-high reset
//   bus (slave)       - host TX/RX handshakes and SPI start/done strobes
//   busy              - a transfer is in flight
//   tx_level/rx_level - TX and RX FIFO occupancy
// Optional build macro SPI_TXN_CTRL_STATS_EN adds:
//   xfer_count  - wrapping count of completed transfers (RX pushes)
//   rx_drop_err - sticky flag, spi_done seen while no transfer was in flight
module spi_txn_ctrl
    import spi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    spi_txn_ctrl_if.slave          bus,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] tx_level,
    output logic [$clog2(DEPTH):0] rx_level
`ifdef SPI_TXN_CTRL_STATS_EN
    ,
    output logic [15:0]            xfer_count,
    output logic                   rx_drop_err
`endif
);

    spi_txn_state_t        state;
    spi_txn_state_t        state_next;
    logic                  tx_full;
    logic                  tx_empty;
    logic                  rx_full;
    logic                  rx_empty;
    logic [SPI_DATA_W-1:0] tx_head;
    logic                  tx_pop;
    logic                  rx_push;

    assign bus.in_ready  = !tx_full;
    assign bus.out_valid = !rx_empty;

    // The TX head leaves the queue in ISSUE; the reply is only accepted in WAIT,
    // so stray done pulses in other states never reach the RX queue.
    assign tx_pop  = (state == ST_ISSUE);
    assign rx_push = (state == ST_WAIT) && bus.spi_done;
    assign busy    = (state == ST_WAIT);

    spi_sync_fifo #(
        .WIDTH (SPI_DATA_W),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_valid),
        .wdata (bus.in_data),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    spi_sync_fifo #(
        .WIDTH (SPI_DATA_W),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .wdata (bus.spi_rx_data),
        .pop   (bus.out_ready),
        .rdata (bus.out_data),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    // A transfer is launched only when its reply is guaranteed a free RX slot;
    // with a single transfer in flight, the reply can never overflow RX.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (!tx_empty && !rx_full) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (bus.spi_done) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // The start strobe and its byte are registered together, so the byte is
    // stable for the whole start cycle and held until the next launch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.spi_start   <= 1'b0;
            bus.spi_tx_data <= '0;
        end else begin
            bus.spi_start <= (state == ST_ISSUE);
            if (state == ST_ISSUE) bus.spi_tx_data <= tx_head;
        end
    end

`ifdef SPI_TXN_CTRL_STATS_EN
    // Transfer counter wraps silently; the drop flag stays set until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_count  <= '0;
            rx_drop_err <= 1'b0;
        end else begin
            if (rx_push) xfer_count <= xfer_count + 16'd1;
            if (bus.spi_done && (state != ST_WAIT)) rx_drop_err <= 1'b1;
        end
    end
`endif

endmodule
